// File: rtl/seq_pattern_ctrl.sv
// Run controller for a programmable serial pattern detector on a 1-bit stream.
// Sequences IDLE -> RUN -> DONE, counting matches and ending on target, timeout or abort.
module seq_pattern_ctrl #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TMO_W   = 16,
    localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic [TMO_W-1:0]   cfg_timeout,
    input  logic               start,
    input  logic               abort,
    input  logic               din_valid,
    input  logic               din,
    output logic               busy,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               done,
    output logic               timed_out,
    output logic               cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   tgt_q, tgt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [MAX_LEN-1:0] sr_q, sr_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [TMO_W-1:0]   bits_q, bits_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               match_q, match_d;
    logic               tout_q, tout_d;
    logic               cerr_q, cerr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] sr_new;
    logic [LEN_W-1:0]   fill_new;
    logic [TMO_W-1:0]   bits_new;
    logic [CNT_W-1:0]   cnt_new;
    logic               hit;
    logic               tgt_end;
    logic               tmo_end;
    logic               cfg_len_ok;

    // Candidate datapath update for a bit accepted this cycle
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
        sr_new     = {sr_q[MAX_LEN-2:0], din};
        fill_new   = (fill_q >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : fill_q + LEN_W'(1);
        bits_new   = (bits_q == '1) ? bits_q : bits_q + TMO_W'(1);
        cnt_new    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        hit        = (fill_new >= len_q) && ((sr_new & len_mask) == (pat_q & len_mask));
        tgt_end    = hit && (tgt_q != '0) && (cnt_new == tgt_q);
        tmo_end    = (tmo_q != '0) && (bits_new == tmo_q);
        cfg_len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; abort takes priority over start and config writes
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        tgt_d   = tgt_q;
        tmo_d   = tmo_q;
        sr_d    = sr_q;
        fill_d  = fill_q;
        bits_d  = bits_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;
        tout_d  = tout_q;
        cerr_d  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    tout_d  = 1'b0;
                end else begin
                    if (cfg_we) begin
                        if (cfg_len_ok) begin
                            pat_d = cfg_pattern;
                            len_d = cfg_len;
                            ovl_d = cfg_overlap;
                            tgt_d = cfg_target;
                            tmo_d = cfg_timeout;
                        end else begin
                            cerr_d = 1'b1;
                        end
                    end
                    if (start) begin
                        if (len_q != '0) begin
                            state_d = S_RUN;
                            sr_d    = '0;
                            fill_d  = '0;
                            bits_d  = '0;
                            cnt_d   = '0;
                            tout_d  = 1'b0;
                        end else begin
                            cerr_d = 1'b1;
                        end
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    tout_d  = 1'b0;
                end else begin
                    cerr_d = cfg_we;
                    if (din_valid) begin
                        sr_d   = sr_new;
                        fill_d = (hit && !ovl_q) ? '0 : fill_new;
                        bits_d = bits_new;
                        if (hit) begin
                            match_d = 1'b1;
                            cnt_d   = cnt_new;
                        end
                        if (tgt_end) begin
                            state_d = S_DONE;
                            tout_d  = 1'b0;
                        end else if (tmo_end) begin
                            state_d = S_DONE;
                            tout_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pulses are guaranteed to drop for at least one cycle between reports
        match_d = match_d && !match_q;
        cerr_d  = cerr_d && !cerr_q;
    end

    // Status flags follow the state being entered
    always_comb begin
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            tgt_q   <= '0;
            tmo_q   <= '0;
            sr_q    <= '0;
            fill_q  <= '0;
            bits_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            tout_q  <= 1'b0;
            cerr_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            tgt_q   <= tgt_d;
            tmo_q   <= tmo_d;
            sr_q    <= sr_d;
            fill_q  <= fill_d;
            bits_q  <= bits_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            tout_q  <= tout_d;
            cerr_q  <= cerr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign match       = match_q;
    assign match_count = cnt_q;
    assign done        = done_q;
    assign timed_out   = tout_q;
    assign cfg_err     = cerr_q;

endmodule

// File: tb/tb_seq_pattern_ctrl.sv
// Scoreboard bench for seq_pattern_ctrl: a behavioural model predicts each bit's outcome,
// expectations are queued when a bit is driven and compared when the registered result appears.
module tb_seq_pattern_ctrl;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TMO_W   = 16;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk;
    logic               rst;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic [TMO_W-1:0]   cfg_timeout;
    logic               start;
    logic               abort;
    logic               din_valid;
    logic               din;
    logic               busy;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               done;
    logic               timed_out;
    logic               cfg_err;

    seq_pattern_ctrl #(
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W),
        .TMO_W  (TMO_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .cfg_target (cfg_target),
        .cfg_timeout(cfg_timeout),
        .start      (start),
        .abort      (abort),
        .din_valid  (din_valid),
        .din        (din),
        .busy       (busy),
        .match      (match),
        .match_count(match_count),
        .done       (done),
        .timed_out  (timed_out),
        .cfg_err    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit m;
        int cnt;
        bit dn;
        bit to;
        bit bz;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    // Model state: 0 idle, 1 run, 2 done
    int m_state, m_pat, m_len, m_ovl, m_tgt, m_tmo;
    int m_hist, m_fill, m_bits, m_cnt;
    bit m_to;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_pat = 0; m_len = 0; m_ovl = 0; m_tgt = 0; m_tmo = 0;
        m_hist = 0; m_fill = 0; m_bits = 0; m_cnt = 0; m_to = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input int pat, input int len, input bit ovl, input int tgt, input int tmo);
        bit err;
        err = (m_state == 1) || (len < 1) || (len > int'(MAX_LEN));
        if (!err) begin
            m_pat = pat; m_len = len; m_ovl = ovl; m_tgt = tgt; m_tmo = tmo;
        end
        cfg_pattern = MAX_LEN'(pat);
        cfg_len     = LEN_W'(len);
        cfg_overlap = ovl;
        cfg_target  = CNT_W'(tgt);
        cfg_timeout = TMO_W'(tmo);
        cfg_we      = 1'b1;
        tick();
        cfg_we = 1'b0;
        check("cfg_err", cfg_err, err);
        tick();
        check("cfg_err_drop", cfg_err, 0);
    endtask

    task automatic do_start();
        bit err;
        err = 1'b0;
        if (m_state != 1) begin
            if (m_len != 0) begin
                m_state = 1; m_hist = 0; m_fill = 0; m_bits = 0; m_cnt = 0; m_to = 0;
            end else begin
                err = 1'b1;
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_err", cfg_err, err);
        check("start_busy", busy, m_state == 1);
        check("start_done", done, m_state == 2);
        tick();
    endtask

    task automatic do_abort(input bit with_start);
        if (m_state != 0) begin
            m_state = 0;
            m_to    = 0;
        end
        abort = 1'b1;
        start = with_start;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_tmo", timed_out, 0);
        check("abort_count", match_count, m_cnt);
        check("abort_err", cfg_err, 0);
    endtask

    // Predict the outcome of one stream bit, queue it, drive it, compare the result
    task automatic send_bit(input bit b);
        exp_t e;
        exp_t got;
        bit   hit;
        hit = 1'b0;
        if (m_state == 1) begin
            m_hist = (m_hist << 1) | int'(b);
            m_fill = (m_fill < int'(MAX_LEN)) ? m_fill + 1 : m_fill;
            m_bits = (m_bits < 65535) ? m_bits + 1 : m_bits;
            hit = (m_fill >= m_len) && ((m_hist & ((1 << m_len) - 1)) == m_pat);
            if (hit) begin
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : m_cnt;
                if (!m_ovl) m_fill = 0;
            end
            if (hit && m_tgt != 0 && m_cnt == m_tgt) begin
                m_state = 2; m_to = 0;
            end else if (m_tmo != 0 && m_bits == m_tmo) begin
                m_state = 2; m_to = 1;
            end
        end
        e.m = hit; e.cnt = m_cnt; e.dn = (m_state == 2); e.to = m_to; e.bz = (m_state == 1);
        sb.push_back(e);
        din       = b;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        got = sb.pop_front();
        check("match", match, got.m);
        check("count", match_count, got.cnt);
        check("done", done, got.dn);
        check("timed_out", timed_out, got.to);
        check("busy", busy, got.bz);
    endtask

    task automatic send_bits(input int n, input int val);
        for (int i = n - 1; i >= 0; i--) send_bit(val[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst = 1'b1; cfg_we = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
        cfg_target = 0; cfg_timeout = 0; start = 0; abort = 0; din_valid = 0; din = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_busy", busy, 0);
        check("rst_match", match, 0);
        check("rst_count", match_count, 0);
        check("rst_done", done, 0);
        check("rst_tmo", timed_out, 0);
        check("rst_err", cfg_err, 0);

        // Unconfigured start and illegal lengths are rejected
        do_start();
        do_cfg(4'b1011, 0, 1, 2, 0);
        do_cfg(4'b1011, 9, 1, 2, 0);

        // Overlapping run ending on target of 2
        do_cfg(4'b1011, 4, 1, 2, 0);
        do_start();
        send_bits(7, 7'b1011011);
        check("t1_count", match_count, 2);
        check("t1_done", done, 1);
        check("t1_tmo", timed_out, 0);
        send_bit(1'b1);

        // Non-overlapping, no target: single match, run continues
        do_cfg(4'b1011, 4, 0, 0, 0);
        do_start();
        send_bits(7, 7'b1011011);
        check("t2_count", match_count, 1);
        check("t2_busy", busy, 1);
        do_cfg(2'b11, 2, 1, 0, 0);
        send_bit(1'b1);
        do_abort(1'b0);
        check("t2_hold", match_count, 1);

        // Timeout end with no matches
        do_cfg(4'b1011, 4, 1, 3, 5);
        do_start();
        send_bits(5, 5'b11111);
        check("t3_tmo", timed_out, 1);
        check("t3_count", match_count, 0);

        // Target and timeout on the same bit: target wins
        do_cfg(4'b1011, 4, 1, 1, 4);
        do_start();
        send_bits(4, 4'b1011);
        check("t4_done", done, 1);
        check("t4_tmo", timed_out, 0);

        // Full-length pattern
        do_cfg(8'b1100_1010, 8, 1, 0, 0);
        do_start();
        send_bits(10, 10'b11_1100_1010);
        check("t5_count", match_count, 1);

        // Abort and start together end the run
        do_abort(1'b1);
        do_start();
        send_bit(1'b1);
        do_abort(1'b1);

        // Reset mid-run clears everything including configuration
        do_start();
        send_bits(2, 2'b10);
        rst = 1'b1;
        #2;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", match_count, 0);
        check("mid_rst_done", done, 0);
        tick();
        rst = 1'b0;
        model_reset();
        do_start();

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
